// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with jumps, CALL/RET stack and HALT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int ADDR_W    = 20,
    parameter int RAS_DEPTH = 8,
    parameter int RESET_PC  = 0,
    parameter int PC_INC    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           op_valid,
    input  logic                           stall,
    input  logic [2:0]                     op,
    input  logic [1:0]                     cc,
    input  logic                           flag_z,
    input  logic                           flag_c,
    input  logic                           flag_n,
    input  logic [ADDR_W-1:0]              target,
    input  logic [ADDR_W-1:0]              offset,
    input  logic                           resume,
    output logic [ADDR_W-1:0]              pc,
    output logic                           taken,
    output logic                           halted,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_inc      = ADDR_W'(PC_INC);
    localparam logic [CW-1:0]     c_full     = CW'(RAS_DEPTH);

    localparam logic [2:0] c_op_jmp  = 3'd1;
    localparam logic [2:0] c_op_jcc  = 3'd2;
    localparam logic [2:0] c_op_jrel = 3'd3;
    localparam logic [2:0] c_op_call = 3'd4;
    localparam logic [2:0] c_op_ret  = 3'd5;
    localparam logic [2:0] c_op_halt = 3'd6;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                taken_q, taken_d;
    logic [PW-1:0]       wr_ptr_q;
    logic [CW-1:0]       count_q;
    logic                ovf_q, unf_q;
    logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];

    logic                w_accept;
    logic                w_cond;
    logic                w_push, w_pop, w_unf;
    logic [ADDR_W-1:0]   w_seq_pc;
    logic [ADDR_W-1:0]   w_top;

    assign w_accept = (state_q == S_RUN) && op_valid && !stall;
    assign w_seq_pc = pc_q + c_inc;
    assign w_top    = ras_q[wr_ptr_q - PW'(1)];

    always_comb begin
        w_cond = 1'b0;
        case (cc)
            2'd0:    w_cond = flag_z;
            2'd1:    w_cond = !flag_z;
            2'd2:    w_cond = flag_c;
            default: w_cond = flag_n;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_unf   = 1'b0;
        if (w_accept) begin
            case (op)
                c_op_jmp: begin
                    pc_d    = target;
                    taken_d = 1'b1;
                end
                c_op_jcc: begin
                    pc_d    = w_cond ? target : w_seq_pc;
                    taken_d = w_cond;
                end
                c_op_jrel: begin
                    pc_d    = pc_q + offset;
                    taken_d = 1'b1;
                end
                c_op_call: begin
                    pc_d    = target;
                    taken_d = 1'b1;
                    w_push  = 1'b1;
                end
                c_op_ret: begin
                    if (count_q == '0) begin
                        pc_d  = w_seq_pc;
                        w_unf = 1'b1;
                    end else begin
                        pc_d    = w_top;
                        taken_d = 1'b1;
                        w_pop   = 1'b1;
                    end
                end
                c_op_halt: pc_d = pc_q;
                default:   pc_d = w_seq_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            pc_q     <= c_reset_pc;
            taken_q  <= 1'b0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            case (state_q)
                S_RUN:   if (w_accept && op == c_op_halt) state_q <= S_HALT;
                default: if (resume && !stall) state_q <= S_RUN;
            endcase
            // A push on a full stack wraps the pointer onto the oldest entry.
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (count_q == c_full) ovf_q <= 1'b1;
                else                   count_q <= count_q + CW'(1);
            end else if (w_pop) begin
                wr_ptr_q <= wr_ptr_q - PW'(1);
                count_q  <= count_q - CW'(1);
            end
            if (w_unf) unf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) ras_q[wr_ptr_q] <= w_seq_pc;
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign halted    = (state_q == S_HALT);
    assign ras_count = count_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed and random stimulus against a queue-based PC model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [1:0]  cc = 2'd0;
    logic        flag_z = 1'b0, flag_c = 1'b0, flag_n = 1'b0;
    logic [19:0] target = '0, offset = '0;
    logic        resume = 1'b0;
    logic [19:0] pc;
    logic        taken, halted, ras_ovf, ras_unf;
    logic [3:0]  ras_count;

    int checks = 0;
    int passed = 0;

    pc_sequencer #(.ADDR_W(20), .RAS_DEPTH(8), .RESET_PC(0), .PC_INC(1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .stall(stall), .op(op), .cc(cc),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .target(target),
        .offset(offset), .resume(resume), .pc(pc), .taken(taken), .halted(halted),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: stack as a queue, newest at the back.
    logic [19:0] m_pc;
    bit          m_taken, m_halted, m_ovf, m_unf, m_live = 0;
    logic [19:0] m_ras[$];

    always @(posedge clk) begin
        bit c;
        if (rst) begin
            m_pc = 20'h0; m_taken = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
            m_ras.delete(); m_live = 1;
        end else if (m_halted) begin
            m_taken = 0;
            if (resume && !stall) m_halted = 0;
        end else if (op_valid && !stall) begin
            m_taken = 0;
            case (op)
                3'd1: begin m_pc = target; m_taken = 1; end
                3'd2: begin
                    c = (cc == 0) ? flag_z : (cc == 1) ? !flag_z : (cc == 2) ? flag_c : flag_n;
                    if (c) begin m_pc = target; m_taken = 1; end
                    else m_pc = m_pc + 20'd1;
                end
                3'd3: begin m_pc = m_pc + offset; m_taken = 1; end
                3'd4: begin
                    if (m_ras.size() == 8) begin void'(m_ras.pop_front()); m_ovf = 1; end
                    m_ras.push_back(m_pc + 20'd1);
                    m_pc = target; m_taken = 1;
                end
                3'd5: begin
                    if (m_ras.size() == 0) begin m_unf = 1; m_pc = m_pc + 20'd1; end
                    else begin m_pc = m_ras.pop_back(); m_taken = 1; end
                end
                3'd6: m_halted = 1;
                default: m_pc = m_pc + 20'd1;
            endcase
        end else begin
            m_taken = 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("pc", 32'(pc), 32'(m_pc));
            chk("taken", 32'(taken), 32'(m_taken));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
            chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
            chk("ras_unf", 32'(ras_unf), 32'(m_unf));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [19:0] t);
        op_valid = 1'b1; op = o; target = t; offset = t;
        cyc();
        op_valid = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_count", 32'(ras_count), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        for (int i = 1; i <= 3; i++) begin
            do_op(3'd0, 20'h0);
            chk("seq_pc", 32'(pc), 32'(i));
            chk("seq_taken", 32'(taken), 32'h0);
        end

        do_op(3'd1, 20'h00010);
        do_op(3'd1, 20'hABCDE);
        chk("jmp_pc", 32'(pc), 32'hABCDE);
        chk("jmp_taken", 32'(taken), 32'h1);
        do_op(3'd3, 20'hFFFFE);
        chk("jrel_back", 32'(pc), 32'hABCDC);
        do_op(3'd1, 20'hFFFFF);
        do_op(3'd3, 20'h00002);
        chk("jrel_wrap", 32'(pc), 32'h00001);
        cyc();
        chk("taken_pulse", 32'(taken), 32'h0);

        cc = 2'd0; flag_z = 1'b1;
        do_op(3'd2, 20'h00400);
        chk("jcc_z_pc", 32'(pc), 32'h00400);
        flag_z = 1'b0;
        do_op(3'd2, 20'h00400);
        chk("jcc_nz_fall", 32'(pc), 32'h00401);
        chk("jcc_fall_taken", 32'(taken), 32'h0);
        cc = 2'd1;
        do_op(3'd2, 20'h00400);
        chk("jcc_nz_taken", 32'(taken), 32'h1);

        do_op(3'd1, 20'h00100);
        do_op(3'd4, 20'h02000);
        chk("call_pc", 32'(pc), 32'h02000);
        chk("call_count", 32'(ras_count), 32'h1);
        do_op(3'd5, 20'h0);
        chk("ret_pc", 32'(pc), 32'h00101);
        chk("ret_count", 32'(ras_count), 32'h0);
        for (int k = 0; k < 9; k++) do_op(3'd4, 20'(32'h1000 * (k + 1)));
        chk("ovf", 32'(ras_ovf), 32'h1);
        chk("ovf_count", 32'(ras_count), 32'h8);
        for (int j = 0; j < 8; j++) begin
            do_op(3'd5, 20'h0);
            chk("lifo_ret", 32'(pc), 32'h1000 * (8 - j) + 1);
        end
        do_op(3'd5, 20'h0);
        chk("unf", 32'(ras_unf), 32'h1);
        chk("unf_pc", 32'(pc), 32'h01002);

        stall = 1'b1;
        do_op(3'd1, 20'h12345);
        chk("stall_pc", 32'(pc), 32'h01002);
        chk("stall_taken", 32'(taken), 32'h0);
        stall = 1'b0;
        do_op(3'd1, 20'h12345);
        chk("unstall_pc", 32'(pc), 32'h12345);

        do_op(3'd6, 20'h0);
        chk("halted", 32'(halted), 32'h1);
        for (int i = 0; i < 5; i++) do_op(3'd0, 20'h0);
        chk("halt_pc", 32'(pc), 32'h12345);
        resume = 1'b1; cyc(); resume = 1'b0;
        chk("resume", 32'(halted), 32'h0);
        chk("resume_pc", 32'(pc), 32'h12345);

        for (int i = 0; i < 3; i++) do_op(3'd4, 20'h00500);
        chk("pre_rst_count", 32'(ras_count), 32'h3);
        rst = 1'b1;
        do_op(3'd4, 20'h00777);
        rst = 1'b0;
        chk("rst_call_pc", 32'(pc), 32'h0);
        chk("rst_call_count", 32'(ras_count), 32'h0);
        chk("rst_flags", 32'({ras_ovf, ras_unf}), 32'h0);

        // Random phase: ops weighted toward CALL/RET so the stack churns.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            op_valid = ($urandom_range(0, 9) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            resume   = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            cc       = 2'($urandom_range(0, 3));
            flag_z   = 1'($urandom); flag_c = 1'($urandom); flag_n = 1'($urandom);
            target   = 20'($urandom);
            offset   = 20'($urandom);
            if (r < 30)      op = 3'd4;
            else if (r < 60) op = 3'd5;
            else if (r < 63) op = 3'd6;
            else             op = 3'($urandom_range(0, 7));
            cyc();
        end
        rst = 1'b0; op_valid = 1'b0; stall = 1'b0; resume = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer, the successor to the combinational JMP block. It holds the PC register and executes one program-flow op per accepted cycle:
- sequential increment;
- absolute, conditional and relative jumps;
- CALL/RET through an internal return-address stack (RAS);
- HALT/resume.

It sits between the decoder/ALU flag outputs and instruction fetch. Its `pc` output drives the fetch address.

Parameters:
- ADDR_W, 20, PC/target width in bits.
- RAS_DEPTH, 8, return-address stack entries (power of 2, ≥2).
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 1, sequential increment added per accepted non-branch op.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  op/target/offset/flags valid this cycle.
- stall  in  1  hold request; freezes all state.
- op  in  3  0 SEQ, 1 JMP, 2 JCC, 3 JREL, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as SEQ).
- cc  in  2  JCC condition: 0 Z, 1 NZ, 2 C, 3 N.
- flag_z, flag_c, flag_n  in  1 each  ALU flags sampled with the op.
- target  in  ADDR_W  absolute address for JMP/JCC/CALL.
- offset  in  ADDR_W  two's-complement displacement for JREL.
- resume  in  1  leaves HALT.
- pc  out  ADDR_W  current program counter (registered).
- taken  out  1  one-cycle pulse: the last accepted op redirected the PC non-sequentially.
- halted  out  1  high in HALT state.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  sticky, set on CALL with RAS full.
- ras_unf  out  1  sticky, set on RET with RAS empty.

Behaviour:
- Reset values (rst high at an edge, overriding all other inputs):
  - pc=RESET_PC; taken=0; halted=0; ras_count=0; ras_ovf=0; ras_unf=0; state=RUN.
  - Reset mid-operation discards any in-flight op and clears the stack.
- FSM has two states, RUN and HALT.
- Acceptance: an op is accepted iff state=RUN && op_valid && !stall.
- Update timing: an accepted op updates pc/RAS/flags at that edge. The new pc is visible the next cycle (latency 1).
- Non-accepted cycles: pc and RAS hold, taken=0.
- Per accepted op:
  - SEQ/reserved: pc ← pc+PC_INC.
  - JMP: pc ← target; taken=1.
  - JCC: if condition true, pc ← target and taken=1; else pc ← pc+PC_INC and taken=0.
  - JREL: pc ← pc+offset; taken=1.
  - CALL: push pc+PC_INC, then pc ← target; taken=1.
  - RET: pop; pc ← popped value; taken=1.
  - HALT: pc holds; state ← HALT; taken=0.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W (wrap, no flag).
- RAS full on CALL (ras_count=RAS_DEPTH):
  - circular buffer overwrites the oldest entry;
  - ras_count stays RAS_DEPTH;
  - ras_ovf ← 1;
  - the jump still occurs.
- RAS empty on RET:
  - pc ← pc+PC_INC;
  - taken=0;
  - ras_unf ← 1;
  - ras_count stays 0.
- RAS_DEPTH=1 is not a legal configuration.
- HALT state:
  - op_valid is ignored and pc holds;
  - resume=1 && !stall → RUN at the next edge (no op accepted that edge);
  - resume while in RUN is ignored.
- Sticky flags clear only on rst.
- ras_count is driven from the registered stack pointer state.
- pc is driven directly from the PC register, with no combinational path from inputs.

Test Plan:
1. Reset → pc=0x00000, ras_count=0, halted=0. Then 3 cycles of SEQ → pc 0x00001, 0x00002, 0x00003, taken=0 throughout.
2. Jumps:
   - pc=0x00010, JMP target=0xABCDE → next cycle pc=0xABCDE, taken pulse 1 cycle.
   - Then JREL offset=0xFFFFE (−2) → pc=0xABCDC.
   - JREL from pc=0xFFFFF with offset 0x00002 → pc=0x00001.
3. Conditional jumps:
   - JCC cc=Z with flag_z=1, target=0x00400 → pc=0x00400, taken=1.
   - Same op with flag_z=0 → pc=0x00401, taken=0.
   - cc=NZ with flag_z=0 → taken.
4. CALL/RET:
   - pc=0x00100, CALL 0x02000 → pc=0x02000, ras_count=1.
   - RET → pc=0x00101, ras_count=0.
   - Nested CALL×9 with RAS_DEPTH=8 → ras_ovf=1, ras_count=8.
   - 8 RETs return the newest 8 addresses in LIFO order.
   - A 9th RET → ras_unf=1, pc+1.
5. Stall: assert stall during JMP 0x12345 → pc unchanged, taken=0. Deassert → jump completes next edge.
6. HALT and reset:
   - HALT → halted=1, SEQ ops ignored for 5 cycles.
   - resume → halted=0 next cycle, pc unchanged.
   - rst asserted during CALL with ras_count=3 → pc=RESET_PC, ras_count=0, flags 0.
